request_arbiter: RTL and testbench

REQUEST_ARBITER -- requirements
Module: request_arbiter

---
 rtl/request_arbiter.sv | 179 +++++++++++++++++
 tb/tb_request_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_arbiter.sv
// request_arbiter
// Picks one of NUM_PORTS pending requests, presents it to a downstream
// fifo_queue and holds it there until the queue accepts it. On acceptance,
// the granted source receives a one-cycle ack pulse.
//
// Configuration macro: REQUEST_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration with a rotating start pointer
//   undefined -> fixed priority, lowest port index wins (no pointer state)
module request_arbiter #(
  parameter int NUM_PORTS                  = 4,
  parameter int PORT_ID_WIDTH_IN_BITS      = 2,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  input  logic [NUM_PORTS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0]    request_packed_in,
  input  logic [NUM_PORTS-1:0]                               request_valid_packed_in,
  output logic [NUM_PORTS-1:0]                               issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]              request_out,
  output logic                                               request_valid_out,
  output logic [PORT_ID_WIDTH_IN_BITS-1:0]                   request_port_id_out,
  input  logic                                               issue_ack_in
);

  localparam int IW = PORT_ID_WIDTH_IN_BITS;
  localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;

  localparam logic [0:0] IDLE_ST = 1'b0;
  localparam logic [0:0] HOLD_ST = 1'b1;

  logic [0:0]           state_r;
  logic [W-1:0]         req_r;
  logic                 valid_r;
  logic [IW-1:0]        id_r;
  logic [NUM_PORTS-1:0] ack_r;

  logic [NUM_PORTS-1:0] eligible_s;
  logic                 any_s;
  logic [IW-1:0]        winner_s;
  logic [W-1:0]         winner_req_s;
  logic [NUM_PORTS-1:0] release_ack_s;
  int                   dist_s;
  int                   best_dist_s;

`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        ptr_next_s;
`endif

  // Eligible requests: a port being acked this cycle is masked so the
  // request it is about to withdraw cannot be granted a second time.
  always_comb begin
    eligible_s = request_valid_packed_in & ~ack_r;
    any_s      = |eligible_s;
  end

  // Winner selection: smallest search distance among eligible ports.
  // Round-robin measures distance from the pointer (with wrap); fixed
  // priority uses the port index itself.
  always_comb begin
    winner_s    = {IW{1'b0}};
    best_dist_s = NUM_PORTS;
    dist_s      = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
      dist_s = j - int'(ptr_r);
      if (dist_s < 0) begin
        dist_s = dist_s + NUM_PORTS;
      end else begin
        dist_s = dist_s;
      end
`else
      dist_s = j;
`endif
      if (eligible_s[j] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        winner_s    = IW'(j);
      end else begin
        best_dist_s = best_dist_s;
        winner_s    = winner_s;
      end
    end
  end

  // Payload mux for the selected port.
  always_comb begin
    winner_req_s = {W{1'b0}};
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (winner_s == IW'(j)) begin
        winner_req_s = request_packed_in[j*W +: W];
      end else begin
        winner_req_s = winner_req_s;
      end
    end
  end

  // One-hot ack vector for the port currently held.
  always_comb begin
    release_ack_s = {NUM_PORTS{1'b0}};
    for (int j = 0; j < NUM_PORTS; j++) begin
      release_ack_s[j] = (id_r == IW'(j));
    end
  end

`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
  // Next pointer: one past the winner, wrapping at the last port.
  always_comb begin
    if (winner_s == IW'(NUM_PORTS - 1)) begin
      ptr_next_s = {IW{1'b0}};
    end else begin
      ptr_next_s = winner_s + IW'(1);
    end
  end

  // Round-robin pointer advances only when a grant is issued.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ptr_r <= {IW{1'b0}};
    end else if ((state_r == IDLE_ST) && any_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Grant/hold/release control with registered outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_r <= IDLE_ST;
      req_r   <= {W{1'b0}};
      valid_r <= 1'b0;
      id_r    <= {IW{1'b0}};
      ack_r   <= {NUM_PORTS{1'b0}};
    end else begin
      case (state_r)
        IDLE_ST: begin
          ack_r <= {NUM_PORTS{1'b0}};
          if (any_s) begin
            state_r <= HOLD_ST;
            req_r   <= winner_req_s;
            valid_r <= 1'b1;
            id_r    <= winner_s;
          end else begin
            state_r <= IDLE_ST;
            req_r   <= {W{1'b0}};
            valid_r <= 1'b0;
            id_r    <= {IW{1'b0}};
          end
        end
        HOLD_ST: begin
          if (issue_ack_in) begin
            state_r <= IDLE_ST;
            req_r   <= {W{1'b0}};
            valid_r <= 1'b0;
            id_r    <= {IW{1'b0}};
            ack_r   <= release_ack_s;
          end else begin
            state_r <= HOLD_ST;
            ack_r   <= {NUM_PORTS{1'b0}};
          end
        end
        default: begin
          state_r <= IDLE_ST;
          req_r   <= {W{1'b0}};
          valid_r <= 1'b0;
          id_r    <= {IW{1'b0}};
          ack_r   <= {NUM_PORTS{1'b0}};
        end
      endcase
    end
  end

  assign issue_ack_out       = ack_r;
  assign request_out         = req_r;
  assign request_valid_out   = valid_r;
  assign request_port_id_out = id_r;

endmodule

// File: tb/tb_request_arbiter.sv
// tb_request_arbiter: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level reference model.
// Works with REQUEST_ARBITER_ROUND_ROBIN_EN either defined or undefined.
module tb_request_arbiter;

  localparam int NP = 4;
  localparam int IW = 2;
  localparam int W  = 32;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic [NP*W-1:0]   request_packed_in;
  logic [NP-1:0]     request_valid_packed_in;
  logic [NP-1:0]     issue_ack_out;
  logic [W-1:0]      request_out;
  logic              request_valid_out;
  logic [IW-1:0]     request_port_id_out;
  logic              issue_ack_in;

  request_arbiter #(
    .NUM_PORTS(NP),
    .PORT_ID_WIDTH_IN_BITS(IW),
    .SINGLE_ENTRY_WIDTH_IN_BITS(W)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_packed_in(request_packed_in),
    .request_valid_packed_in(request_valid_packed_in),
    .issue_ack_out(issue_ack_out),
    .request_out(request_out),
    .request_valid_out(request_valid_out),
    .request_port_id_out(request_port_id_out),
    .issue_ack_in(issue_ack_in)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: is a grant outstanding, for whom, with what payload,
  // which port is being acked this cycle (-1 none), round-robin start.
  int          m_busy;
  int          m_id;
  logic [31:0] m_req;
  int          m_ack;
  int          m_ptr;

  int          grants[$];
  int          accepted;
  int          prev_valid;
  logic [NP-1:0] ack_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_req = 32'h0; m_ack = -1; m_ptr = 0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_eval();
    int w;
    int p;
    w = -1;
    if (m_busy == 0) begin
      for (int k = 0; k < NP; k++) begin
`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
        p = (m_ptr + k) % NP;
`else
        p = k;
`endif
        if (w < 0 && request_valid_packed_in[p] && m_ack != p) w = p;
      end
      m_ack = -1;
      if (w >= 0) begin
        m_busy = 1;
        m_id   = w;
        m_req  = request_packed_in[w*W +: W];
        m_ptr  = (w + 1) % NP;
      end
    end else begin
      m_ack = -1;
      if (issue_ack_in) begin
        m_ack  = m_id;
        m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NP-1:0] exp_ack;
    exp_ack = (m_ack >= 0) ? (4'b0001 << m_ack) : 4'b0000;
    check("request_valid_out", 64'(request_valid_out), 64'(m_busy != 0));
    check("request_out", 64'(request_out), (m_busy != 0) ? 64'(m_req) : 64'h0);
    check("request_port_id_out", 64'(request_port_id_out), (m_busy != 0) ? 64'(m_id) : 64'h0);
    check("issue_ack_out", 64'(issue_ack_out), 64'(exp_ack));
    check("ack_onehot", 64'($countones(issue_ack_out) <= 1), 64'h1);
  endtask

  task automatic step();
    if (issue_ack_in && request_valid_out) accepted++;
    model_eval();
    @(posedge clk_in);
    #1;
    if (request_valid_out && prev_valid == 0) grants.push_back(int'(request_port_id_out));
    prev_valid = int'(request_valid_out);
    compare_all();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(request_valid_out), 64'h0);
    check({tag, "_req"},   64'(request_out), 64'h0);
    check({tag, "_id"},    64'(request_port_id_out), 64'h0);
    check({tag, "_ack"},   64'(issue_ack_out), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order[5];
    int first_id;
    logic [3:0] v;

`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 1, 0, 1, 0};
`endif

    reset_in = 1'b1;
    request_packed_in = '0;
    request_valid_packed_in = 4'b0000;
    issue_ack_in = 1'b0;
    model_reset();
    prev_valid = 0;
    accepted = 0;
    ack_prev = 4'b0000;
    repeat (2) @(posedge clk_in);
    #1;
    check_zero_outputs("reset");
    reset_in = 1'b0;
    step();

    // All ports valid continuously, downstream acks immediately.
    for (int i = 0; i < NP; i++) request_packed_in[i*W +: W] = 32'h1000_0000 + 32'(i);
    request_valid_packed_in = 4'b1111;
    grants.delete();
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      issue_ack_in = request_valid_out;
      step();
    end
    check("fair_grant_count", 64'(grants.size() >= 5), 64'h1);
    for (int k = 0; k < 5; k++) begin
      if (k < grants.size()) check("fair_order", 64'(grants[k]), 64'(exp_order[k]));
    end
    request_valid_packed_in = 4'b0000;
    issue_ack_in = 1'b1;
    repeat (3) step();
    issue_ack_in = 1'b0;
    step();

    // Single request on port 2.
    request_packed_in[2*W +: W] = 32'hDEAD_BEEF;
    request_valid_packed_in = 4'b0100;
    step();
    check("single_valid", 64'(request_valid_out), 64'h1);
    check("single_req", 64'(request_out), 64'hDEAD_BEEF);
    check("single_id", 64'(request_port_id_out), 64'h2);
    step();
    issue_ack_in = 1'b1;
    step();
    check("single_ack", 64'(issue_ack_out), 64'h4);
    check("single_valid_clr", 64'(request_valid_out), 64'h0);
    issue_ack_in = 1'b0;
    request_valid_packed_in = 4'b0000;
    step();

    // Ports 1 and 3 competing.
    request_packed_in[1*W +: W] = 32'h1111_1111;
    request_packed_in[3*W +: W] = 32'h3333_3333;
    request_valid_packed_in = 4'b1010;
    step();
    first_id = int'(request_port_id_out);
`ifdef REQUEST_ARBITER_ROUND_ROBIN_EN
    check("prio_first", 64'(first_id), 64'h3);
`else
    check("prio_first", 64'(first_id), 64'h1);
`endif
    issue_ack_in = 1'b1;
    step();
    issue_ack_in = 1'b0;
    request_valid_packed_in[first_id] = 1'b0;
    step();
    check("prio_second", 64'(request_port_id_out), 64'(4 - first_id));
    issue_ack_in = 1'b1;
    step();
    issue_ack_in = 1'b0;
    request_valid_packed_in = 4'b0000;
    step();

    // Backpressure: grant held for 10 cycles while other valids churn.
    request_packed_in[0*W +: W] = 32'hCAFE_0000;
    request_valid_packed_in = 4'b0001;
    step();
    for (int c = 0; c < 10; c++) begin
      v = 4'($urandom_range(0, 15));
      request_valid_packed_in = {v[3:1], 1'b1};
      step();
      check("bp_req", 64'(request_out), 64'hCAFE_0000);
      check("bp_id", 64'(request_port_id_out), 64'h0);
      check("bp_noack", 64'(issue_ack_out), 64'h0);
    end
    request_valid_packed_in = 4'b0001;
    issue_ack_in = 1'b1;
    step();
    issue_ack_in = 1'b0;
    request_valid_packed_in = 4'b0000;
    repeat (3) step();

    // No double grant: port 0 keeps valid during its ack pulse cycle.
    grants.delete();
    accepted = 0;
    request_packed_in[0*W +: W] = 32'h0BAD_F00D;
    request_valid_packed_in = 4'b0001;
    step();
    issue_ack_in = 1'b1;
    step();
    issue_ack_in = 1'b0;
    step();
    check("nodbl_valid", 64'(request_valid_out), 64'h0);
    request_valid_packed_in = 4'b0000;
    repeat (3) step();
    check("nodbl_grants", 64'(grants.size()), 64'h1);
    check("nodbl_fifo", 64'(accepted), 64'h1);

    // Reset in the middle of a held grant.
    request_packed_in[1*W +: W] = 32'h1234_5678;
    request_packed_in[2*W +: W] = 32'h8765_4321;
    request_valid_packed_in = 4'b0110;
    step();
    check("rst_pre_valid", 64'(request_valid_out), 64'h1);
    #3;
    reset_in = 1'b1;
    #1;
    check_zero_outputs("rst_async");
    @(posedge clk_in);
    #1;
    check_zero_outputs("rst_held");
    reset_in = 1'b0;
    model_reset();
    prev_valid = 0;
    step();
    check("rst_regrant_id", 64'(request_port_id_out), 64'h1);
    check("rst_regrant_req", 64'(request_out), 64'h1234_5678);
    request_valid_packed_in = 4'b0000;
    issue_ack_in = 1'b1;
    repeat (2) step();
    issue_ack_in = 1'b0;
    step();

    // Randomized traffic with protocol-following sources.
    ack_prev = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (ack_prev[i]) begin
          request_valid_packed_in[i] = 1'b0;
        end else if (!request_valid_packed_in[i] && $urandom_range(0, 3) == 0) begin
          request_valid_packed_in[i] = 1'b1;
          request_packed_in[i*W +: W] = $urandom;
        end
      end
      issue_ack_in = ($urandom_range(0, 2) == 0);
      step();
      ack_prev = issue_ack_out;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
